// File: rtl/mdio_master_if.sv
// Command/response and MDIO pad bundle for mdio_master.
// The master modport is the serializer's view; slave is the requester/PHY side.
interface mdio_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic        mdc;
    logic        mdio_in;
    logic        mdio_out;
    logic        mdio_oen;

    modport master (
        input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata, mdio_in,
        output cmd_ready, rsp_valid, rsp_rdata, busy, mdc, mdio_out, mdio_oen
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata, mdio_in,
        input  cmd_ready, rsp_valid, rsp_rdata, busy, mdc, mdio_out, mdio_oen
    );
endinterface

// File: rtl/mdio_master.sv
// Clause-22 MDIO frame master: serializes one read/write command per frame on mdc/mdio.
// Define MDIO_PREAMBLE_EN to emit the 32-bit preamble; otherwise frames are preamble-suppressed.
module mdio_master #(
    parameter int CLK_DIV = 10
) (
    input  logic          clkin_50,
    input  logic          reset,
    mdio_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        HDR  = 3'd2,
        TA   = 3'd3,
        DATA = 3'd4,
        DONE = 3'd5
    } state_t;

`ifdef MDIO_PREAMBLE_EN
    localparam state_t FIRST = PRE;
`else
    localparam state_t FIRST = HDR;
`endif

    localparam logic [8:0] HALF = 9'(CLK_DIV);
    localparam logic [8:0] LAST = 9'(2 * CLK_DIV - 1);

    state_t      state_r, state_nx_s;
    logic [8:0]  cnt_r, cnt_nx_s;
    logic [4:0]  bit_r, bit_nx_s;
    logic        write_r;
    logic [4:0]  phy_r, reg_r;
    logic [15:0] wdata_r, shift_r, rsp_rdata_r;
    logic        cmd_ready_r, busy_r, rsp_valid_r, mdc_r, mdio_out_r, mdio_oen_r;
    logic        accept_s, bit_end_s, in_frame_s, drive_s, bit_val_s;
    logic [13:0] hdr_s;

    function automatic logic [4:0] phase_last(input state_t s);
        case (s)
            PRE:     phase_last = 5'd31;
            HDR:     phase_last = 5'd13;
            TA:      phase_last = 5'd1;
            DATA:    phase_last = 5'd15;
            default: phase_last = 5'd0;
        endcase
    endfunction

    function automatic state_t phase_next(input state_t s);
        case (s)
            PRE:     phase_next = HDR;
            HDR:     phase_next = TA;
            TA:      phase_next = DATA;
            DATA:    phase_next = DONE;
            default: phase_next = IDLE;
        endcase
    endfunction

    assign accept_s   = (state_r == IDLE) && cmd_ready_r && bus.cmd_valid;
    assign bit_end_s  = (cnt_r == LAST);
    assign in_frame_s = state_r inside {PRE, HDR, TA, DATA};

    // Next-state: bit-clock counter, bit index within the phase, phase sequencing.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        bit_nx_s   = bit_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = FIRST;
                    cnt_nx_s   = 9'd0;
                    bit_nx_s   = 5'd0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            PRE, HDR, TA, DATA: begin
                if (!bit_end_s) begin
                    cnt_nx_s = cnt_r + 9'd1;
                end else if (bit_r == phase_last(state_r)) begin
                    cnt_nx_s   = 9'd0;
                    bit_nx_s   = 5'd0;
                    state_nx_s = phase_next(state_r);
                end else begin
                    cnt_nx_s = 9'd0;
                    bit_nx_s = bit_r + 5'd1;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Serial bit selection; read turnaround and data leave the pad released.
    always_comb begin
        hdr_s     = {2'b01, (write_r ? 2'b01 : 2'b10), phy_r, reg_r};
        drive_s   = 1'b0;
        bit_val_s = 1'b1;
        case (state_r)
            PRE: begin
                drive_s   = 1'b1;
                bit_val_s = 1'b1;
            end
            HDR: begin
                drive_s   = 1'b1;
                bit_val_s = hdr_s[4'd13 - bit_r[3:0]];
            end
            TA: begin
                drive_s   = write_r;
                bit_val_s = write_r ? (bit_r == 5'd0) : 1'b1;
            end
            DATA: begin
                drive_s   = write_r;
                bit_val_s = write_r ? wdata_r[4'd15 - bit_r[3:0]] : 1'b1;
            end
            default: begin
                drive_s   = 1'b0;
                bit_val_s = 1'b1;
            end
        endcase
    end

    // State, captured command and registered outputs; pad outputs trail the counters by one clock.
    always_ff @(posedge clkin_50 or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 9'd0;
            bit_r       <= 5'd0;
            write_r     <= 1'b0;
            phy_r       <= 5'd0;
            reg_r       <= 5'd0;
            wdata_r     <= 16'h0000;
            shift_r     <= 16'h0000;
            rsp_rdata_r <= 16'h0000;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            mdc_r       <= 1'b0;
            mdio_out_r  <= 1'b1;
            mdio_oen_r  <= 1'b1;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            bit_r   <= bit_nx_s;
            if (accept_s) begin
                write_r <= bus.cmd_write;
                phy_r   <= bus.cmd_phy_addr;
                reg_r   <= bus.cmd_reg_addr;
                wdata_r <= bus.cmd_wdata;
            end
            // The PHY launches data after mdc falls; capture on the clock mdc rises.
            if ((state_r == DATA) && (cnt_r == HALF)) begin
                shift_r <= {shift_r[14:0], bus.mdio_in};
            end
            if (state_r == DONE) begin
                rsp_rdata_r <= write_r ? 16'h0000 : shift_r;
            end
            cmd_ready_r <= (state_nx_s == IDLE) && (state_r == IDLE);
            busy_r      <= (state_nx_s != IDLE);
            rsp_valid_r <= (state_r == DONE);
            mdc_r       <= in_frame_s && (cnt_r >= HALF);
            mdio_out_r  <= drive_s ? bit_val_s : 1'b1;
            mdio_oen_r  <= ~drive_s;
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.busy      = busy_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.mdc       = mdc_r;
    assign bus.mdio_out  = mdio_out_r;
    assign bus.mdio_oen  = mdio_oen_r;
endmodule
